// File: rtl/shift_right_sequential.sv
// -----------------------------------------------------------------------------
// shift_right_sequential
//
// Multi-cycle right shifter (logical or arithmetic) for the ALU datapath.
// The shift is made up of S binary-weighted stages. Stage k shifts by 2^k when
// shamt[k] is set, and one stage is applied per clock. BUSY therefore always
// lasts exactly S cycles, whatever the shift amount.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; drops any in-flight operation
//   in_valid   upstream offers an operation
//   in_ready   high only in IDLE
//   in         operand to shift right (N bits)
//   shamt      shift amount 0..N-1 (S bits)
//   arith      1 = sign fill, 0 = zero fill
//   out_valid  high only in DONE
//   out_ready  downstream takes the result
//   out        shifted result; keeps its value after the handshake
//   busy       high in BUSY or DONE
// -----------------------------------------------------------------------------
module shift_right_sequential #(
    parameter int N = 32,
    parameter int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in,
    input  logic [S-1:0] shamt,
    input  logic         arith,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         busy
);

    // The stage counter runs from 0 to S-1.
    localparam int CW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg;
    logic [N-1:0]  work_reg;
    logic [S-1:0]  sh_reg;
    logic          ar_reg;
    logic          msb_reg;
    logic [CW-1:0] cnt_reg;
    logic [N-1:0]  out_reg;
    logic          in_ready_reg;
    logic          out_valid_reg;
    logic          busy_reg;

    logic          fill;
    logic          last_stage;
    logic [N-1:0]  work_next;
    logic [N-1:0]  stage_res [S];

    // The sign is captured from the original operand when the operation is
    // accepted. The intermediate work value is never used for sign fill, so
    // an earlier logical-looking stage cannot change the fill bit.
    assign fill       = ar_reg & msb_reg;
    assign last_stage = (cnt_reg == CW'(S - 1));

    // One candidate per stage: work shifted right by 2^gi with fill on top.
    generate
        for (genvar gi = 0; gi < S; gi++) begin : g_stage
            localparam int D = 1 << gi;
            assign stage_res[gi] = {{D{fill}}, work_reg[N-1:D]};
        end
    endgenerate

    always_comb begin
        work_next = work_reg;
        if (sh_reg[cnt_reg]) begin
            work_next = stage_res[cnt_reg];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            work_reg      <= '0;
            sh_reg        <= '0;
            ar_reg        <= 1'b0;
            msb_reg       <= 1'b0;
            cnt_reg       <= '0;
            out_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg    <= BUSY;
                        work_reg     <= in;
                        sh_reg       <= shamt;
                        ar_reg       <= arith;
                        msb_reg      <= in[N-1];
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                BUSY: begin
                    work_reg <= work_next;
                    cnt_reg  <= cnt_reg + CW'(1);
                    if (last_stage) begin
                        // The result register is loaded straight from the
                        // final stage so out and out_valid rise together.
                        state_reg     <= DONE;
                        out_reg       <= work_next;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign out       = out_reg;

endmodule

// File: tb/tb_shift_right_sequential.sv
module tb_shift_right_sequential;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in;
    logic [4:0]  shamt;
    logic        arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        busy;

    int tests;
    int failures;

    shift_right_sequential dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .shamt     (shamt),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an operation and hold it until the edge that accepts it.
    task automatic start_op(input logic [31:0] x, input logic [4:0] s, input logic a);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        in       = x;
        shamt    = s;
        arith    = a;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count cycles after the accept edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Full operation with out_ready held high; returns result and latency.
    task automatic run_op(input logic [31:0] x, input logic [4:0] s, input logic a,
                          output logic [31:0] res, output int lat);
        out_ready = 1'b1;
        start_op(x, s, a);
        wait_out(lat);
        res = out;
        tick();
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] exp;
        logic [31:0] rx;
        logic [4:0]  rs;
        logic        ra;
        int          lat;
        int          n;
        int          delivered;
        int          dup;
        int          bad_lat;

        tests     = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in        = '0;
        shamt     = '0;
        arith     = 1'b0;
        out_ready = 1'b0;

        // ---- reset state ----
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out",       out,            32'h0);
        #1 rst_n = 1'b1;
        tick();

        // ---- logical, full-width shift ----
        run_op(32'h80000000, 5'd31, 1'b0, res, lat);
        check("log_31",     res,     32'h00000001);
        check("log_31_lat", 32'(lat), 32'd5);

        // ---- arithmetic vs logical on the same operand ----
        run_op(32'h80000000, 5'd4, 1'b1, res, lat);
        check("ari_4", res, 32'hF8000000);
        run_op(32'h80000000, 5'd4, 1'b0, res, lat);
        check("log_4", res, 32'h08000000);

        // ---- shamt = 0 still takes five cycles ----
        run_op(32'hDEADBEEF, 5'd0, 1'b1, res, lat);
        check("sh0",     res,     32'hDEADBEEF);
        check("sh0_lat", 32'(lat), 32'd5);

        // ---- positive operand, arithmetic full shift ----
        run_op(32'h7FFFFFFF, 5'd31, 1'b1, res, lat);
        check("ari_pos_31", res, 32'h00000000);
        run_op(32'h80000001, 5'd16, 1'b1, res, lat);
        check("ari_16", res, 32'hFFFF8000);

        // ---- asynchronous reset in the middle of BUSY ----
        out_ready = 1'b1;
        start_op(32'hFFFF0000, 5'd4, 1'b1);
        tick();
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out",       out,            32'h0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_busy",      32'(busy),      32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(32'hFFFF0000, 5'd4, 1'b1, res, lat);
        check("post_rst",     res,     32'hFFFFF000);
        check("post_rst_lat", 32'(lat), 32'd5);

        // ---- backpressure: result held, new requests ignored ----
        out_ready = 1'b0;
        start_op(32'h12345678, 5'd8, 1'b0);
        wait_out(lat);
        check("bp_lat", 32'(lat), 32'd5);
        in       = 32'hF0000000;
        shamt    = 5'd4;
        arith    = 1'b1;
        in_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out !== 32'h00123456 || in_ready !== 1'b0 || out_valid !== 1'b1) n++;
        end
        check("bp_hold_errs", 32'(n), 32'd0);
        check("bp_out",       out,    32'h00123456);
        out_ready = 1'b1;
        tick();
        check("bp_rel_valid", 32'(out_valid), 32'd0);
        check("bp_rel_ready", 32'(in_ready),  32'd1);
        check("bp_rel_out",   out,            32'h00123456);
        tick();
        in_valid = 1'b0;
        check("bp_new_busy", 32'(busy), 32'd1);
        wait_out(lat);
        check("bp_new",     out,     32'hFF000000);
        check("bp_new_lat", 32'(lat), 32'd5);
        tick();

        // ---- randomised ops with random backpressure and junk inputs ----
        delivered = 0;
        dup       = 0;
        bad_lat   = 0;
        for (int i = 0; i < 1000; i++) begin
            rx = $urandom;
            rs = 5'($urandom_range(0, 31));
            ra = 1'($urandom_range(0, 1));
            exp = ra ? 32'($signed(rx) >>> rs) : (rx >> rs);
            out_ready = 1'($urandom_range(0, 1));
            start_op(rx, rs, ra);
            // Junk presented while the block is busy must be ignored.
            in       = $urandom;
            shamt    = 5'($urandom_range(0, 31));
            arith    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            wait_out(lat);
            if (lat != 5) bad_lat++;
            n = 0;
            while (n < 40) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    check($sformatf("rand_%0d", i), out, exp);
                    delivered++;
                    tick();
                    if (out_valid) dup++;
                    break;
                end
                tick();
                n++;
            end
            in_valid = 1'b0;
        end
        check("rand_delivered", 32'(delivered), 32'd1000);
        check("rand_dup",       32'(dup),       32'd0);
        check("rand_bad_lat",   32'(bad_lat),   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
